// File: rtl/core_pkg.sv
// core_pkg: shared constants for the memory-access stage.
// Contents: memory operation size encodings and the MA FSM state type.
// No ports; imported by core_ma and core_ma_lsu_align.
package core_pkg;

  // em_mem_op_type encodings; the fourth code (3) behaves as a word.
  localparam logic [1:0] MEM_OP_BYTE = 2'd0;
  localparam logic [1:0] MEM_OP_HALF = 2'd1;
  localparam logic [1:0] MEM_OP_WORD = 2'd2;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_RESP = 2'd2
  } ma_state_t;

endpackage

// File: rtl/core_ma_lsu_align.sv
// core_ma_lsu_align: purely combinational lane logic for the MA stage.
// Request side: byte enables, lane-replicated store data, misalign flag.
// Load side: lane select plus sign/zero extension of the returned bus word.
module core_ma_lsu_align
  import core_pkg::*;
(
  input  logic [1:0]  req_off,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_data,
  output logic [3:0]  req_byte_en,
  output logic [31:0] req_wdata,
  output logic        req_misalign,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_op,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    // Word (and the reserved code) is the default case.
    req_byte_en  = 4'b1111;
    req_wdata    = req_data;
    req_misalign = (req_off != 2'b00);
    case (req_op)
      MEM_OP_BYTE: begin
        req_byte_en  = 4'b0001 << req_off;
        req_wdata    = {4{req_data[7:0]}};
        req_misalign = 1'b0;
      end
      MEM_OP_HALF: begin
        req_byte_en  = req_off[1] ? 4'b1100 : 4'b0011;
        req_wdata    = {2{req_data[15:0]}};
        req_misalign = req_off[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
    ld_half = ld_rdata[{ld_off[1], 4'b0000} +: 16];
    case (ld_op)
      MEM_OP_BYTE: ld_data = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
      MEM_OP_HALF: ld_data = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
      default:     ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/core_ma.sv
// core_ma: memory-access pipeline stage between EX/MEM and MA/WB registers.
// Ports: em_* entry in (valid/ready), mw_* entry out (valid/ready, also the
// EX bypass source), bus_* single-outstanding data bus, ma_* misalign report.
module core_ma
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rest,
  input  logic        em_valid,
  input  logic        em_start_handle,
  output logic        em_ready,
  input  logic [31:0] em_reg_data_mem_addr,
  input  logic [31:0] em_csr_data_mem_data,
  input  logic        em_mem_read,
  input  logic        em_mem_write,
  input  logic [1:0]  em_mem_op_type,
  input  logic        em_mem_unsigned,
  input  logic [4:0]  em_rd,
  input  logic        em_reg_write,
  input  logic [11:0] em_csr,
  input  logic        em_csr_write,
  output logic        mw_valid,
  input  logic        mw_ready,
  output logic [4:0]  mw_rd,
  output logic        mw_reg_write,
  output logic [31:0] mw_reg_write_data,
  output logic        mw_mem_data_valid,
  output logic [11:0] mw_csr,
  output logic        mw_csr_write,
  output logic [31:0] mw_csr_data,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byte_en,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rdata_valid,
  output logic        ma_misalign,
  output logic [31:0] ma_bad_addr
);

  ma_state_t   state;
  logic [1:0]  ld_off_q;
  logic [1:0]  ld_op_q;
  logic        ld_unsigned_q;

  logic        accept;
  logic        is_mem;
  logic        retire;
  logic        misalign;
  logic        bus_start;
  logic        load_done;
  logic [3:0]  req_byte_en;
  logic [31:0] req_wdata;
  logic [31:0] ld_data;

  // Start-of-entry marker carries no control meaning here.
  logic unused_start_handle;
  assign unused_start_handle = em_start_handle;

  core_ma_lsu_align u_align (
    .req_off      (em_reg_data_mem_addr[1:0]),
    .req_op       (em_mem_op_type),
    .req_data     (em_csr_data_mem_data),
    .req_byte_en  (req_byte_en),
    .req_wdata    (req_wdata),
    .req_misalign (misalign),
    .ld_off       (ld_off_q),
    .ld_op        (ld_op_q),
    .ld_unsigned  (ld_unsigned_q),
    .ld_rdata     (bus_rdata),
    .ld_data      (ld_data)
  );

  // bus_valid is decoded from state so the async reset drops it at once.
  assign bus_valid = (state == MA_REQ);
  // A pending load blocks retirement of the MW entry, and so new entries.
  assign em_ready  = (state == MA_IDLE) &&
                     (!mw_valid || (mw_ready && mw_mem_data_valid));
  assign accept    = em_valid && em_ready;
  assign is_mem    = em_mem_read || em_mem_write;
  assign retire    = mw_valid && mw_mem_data_valid && mw_ready;
  assign bus_start = accept && is_mem && !misalign;
  // rdata in REQ (even alongside bus_ready) is never treated as load data.
  assign load_done = (state == MA_RESP) && bus_rdata_valid;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state <= MA_IDLE;
    end else begin
      case (state)
        MA_IDLE: if (bus_start)       state <= MA_REQ;
        MA_REQ:  if (bus_ready)       state <= bus_write ? MA_IDLE : MA_RESP;
        MA_RESP: if (bus_rdata_valid) state <= MA_IDLE;
        default:                      state <= MA_IDLE;
      endcase
    end
  end

  // Request fields and load lane info are captured once at accept and held
  // stable for the whole REQ/RESP period.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      bus_write     <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_byte_en   <= '0;
      ld_off_q      <= '0;
      ld_op_q       <= '0;
      ld_unsigned_q <= 1'b0;
    end else if (bus_start) begin
      bus_write     <= !em_mem_read;
      bus_addr      <= {em_reg_data_mem_addr[31:2], 2'b00};
      bus_wdata     <= req_wdata;
      bus_byte_en   <= req_byte_en;
      ld_off_q      <= em_reg_data_mem_addr[1:0];
      ld_op_q       <= em_mem_op_type;
      ld_unsigned_q <= em_mem_unsigned;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      ma_misalign <= 1'b0;
      ma_bad_addr <= '0;
    end else begin
      ma_misalign <= accept && is_mem && misalign;
      if (accept && is_mem && misalign) ma_bad_addr <= em_reg_data_mem_addr;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      mw_valid          <= 1'b0;
      mw_rd             <= '0;
      mw_reg_write      <= 1'b0;
      mw_reg_write_data <= '0;
      mw_mem_data_valid <= 1'b0;
      mw_csr            <= '0;
      mw_csr_write      <= 1'b0;
      mw_csr_data       <= '0;
    end else if (accept) begin
      mw_valid    <= 1'b1;
      mw_rd       <= em_rd;
      mw_csr      <= em_csr;
      mw_csr_data <= em_csr_data_mem_data;
      if (!is_mem) begin
        mw_reg_write      <= em_reg_write;
        mw_reg_write_data <= em_reg_data_mem_addr;
        mw_mem_data_valid <= 1'b1;
        mw_csr_write      <= em_csr_write;
      end else if (misalign) begin
        // Faulting access retires as a no-op entry.
        mw_reg_write      <= 1'b0;
        mw_reg_write_data <= '0;
        mw_mem_data_valid <= 1'b1;
        mw_csr_write      <= 1'b0;
      end else if (em_mem_read) begin
        // Load entry is visible to bypass immediately but marked not final.
        mw_reg_write      <= em_reg_write;
        mw_reg_write_data <= '0;
        mw_mem_data_valid <= 1'b0;
        mw_csr_write      <= em_csr_write;
      end else begin
        mw_reg_write      <= 1'b0;
        mw_reg_write_data <= '0;
        mw_mem_data_valid <= 1'b1;
        mw_csr_write      <= em_csr_write;
      end
    end else begin
      if (load_done) begin
        mw_reg_write_data <= ld_data;
        mw_mem_data_valid <= 1'b1;
      end
      if (retire) mw_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_core_ma.sv
// tb_core_ma: directed plus randomized bench for core_ma.
// A transaction-level model predicts em_ready, the MW entry, the misalign
// report and the bus request; outputs are compared at every negedge.
module tb_core_ma;

  logic        clk = 1'b0;
  logic        rest;
  logic        em_valid, em_start_handle, em_ready;
  logic [31:0] em_reg_data_mem_addr, em_csr_data_mem_data;
  logic        em_mem_read, em_mem_write, em_mem_unsigned;
  logic [1:0]  em_mem_op_type;
  logic [4:0]  em_rd;
  logic        em_reg_write;
  logic [11:0] em_csr;
  logic        em_csr_write;
  logic        mw_valid, mw_ready;
  logic [4:0]  mw_rd;
  logic        mw_reg_write, mw_mem_data_valid, mw_csr_write;
  logic [31:0] mw_reg_write_data, mw_csr_data;
  logic [11:0] mw_csr;
  logic        bus_valid, bus_ready, bus_write, bus_rdata_valid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byte_en;
  logic        ma_misalign;
  logic [31:0] ma_bad_addr;

  always #5 clk = ~clk;

  core_ma dut (
    .clk(clk), .rest(rest),
    .em_valid(em_valid), .em_start_handle(em_start_handle), .em_ready(em_ready),
    .em_reg_data_mem_addr(em_reg_data_mem_addr), .em_csr_data_mem_data(em_csr_data_mem_data),
    .em_mem_read(em_mem_read), .em_mem_write(em_mem_write), .em_mem_op_type(em_mem_op_type),
    .em_mem_unsigned(em_mem_unsigned), .em_rd(em_rd), .em_reg_write(em_reg_write),
    .em_csr(em_csr), .em_csr_write(em_csr_write),
    .mw_valid(mw_valid), .mw_ready(mw_ready), .mw_rd(mw_rd), .mw_reg_write(mw_reg_write),
    .mw_reg_write_data(mw_reg_write_data), .mw_mem_data_valid(mw_mem_data_valid),
    .mw_csr(mw_csr), .mw_csr_write(mw_csr_write), .mw_csr_data(mw_csr_data),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en), .bus_rdata(bus_rdata),
    .bus_rdata_valid(bus_rdata_valid), .ma_misalign(ma_misalign), .ma_bad_addr(ma_bad_addr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_phase: 0 = no bus work, 1 = request outstanding, 2 = awaiting load data
  logic        m_valid, m_rw, m_dv, m_csrw, m_mis, m_bwr, m_ld_uns;
  logic [4:0]  m_rd;
  logic [31:0] m_wd, m_csrd, m_bad, m_baddr, m_bwd;
  logic [11:0] m_csr;
  logic [3:0]  m_be;
  logic [1:0]  m_ld_off, m_ld_op;
  int          m_phase, m_lat;

  task automatic m_reset();
    m_valid = 0; m_rw = 0; m_dv = 0; m_csrw = 0; m_mis = 0; m_bwr = 0; m_ld_uns = 0;
    m_rd = 0; m_wd = 0; m_csrd = 0; m_bad = 0; m_baddr = 0; m_bwd = 0; m_csr = 0;
    m_be = 0; m_ld_off = 0; m_ld_op = 0; m_phase = 0; m_lat = 0;
  endtask

  function automatic int f_nbytes(input logic [1:0] op);
    return (op == 2'd0) ? 1 : (op == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] f_extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] op, input logic uns);
    int nb;
    logic [31:0] mask, v;
    nb = f_nbytes(op);
    if (nb == 4) return w;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v = (w >> (8 * int'(off))) & mask;
    if (!uns && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic exp_ready();
    return (m_phase == 0) && (!m_valid || (mw_ready && m_dv));
  endfunction

  // Advance the model across one rising edge using the inputs applied.
  task automatic model_step();
    logic acc, ret;
    int nb;
    logic [31:0] a, d;
    acc = em_valid && exp_ready();
    ret = m_valid && m_dv && mw_ready;
    m_mis = 0;
    if (m_phase == 1 && bus_ready) begin
      m_phase = m_bwr ? 0 : 2;
      m_lat = $urandom_range(0, 2);
    end else if (m_phase == 2 && bus_rdata_valid) begin
      m_wd = f_extract(bus_rdata, m_ld_off, m_ld_op, m_ld_uns);
      m_dv = 1;
      m_phase = 0;
    end
    if (acc) begin
      a = em_reg_data_mem_addr;
      d = em_csr_data_mem_data;
      nb = f_nbytes(em_mem_op_type);
      m_valid = 1; m_rd = em_rd; m_csr = em_csr; m_csrd = d;
      if (!(em_mem_read || em_mem_write)) begin
        m_rw = em_reg_write; m_wd = a; m_dv = 1; m_csrw = em_csr_write;
      end else if ((int'(a[1:0]) % nb) != 0) begin
        m_mis = 1; m_bad = a; m_rw = 0; m_csrw = 0; m_dv = 1;
      end else begin
        m_phase = 1;
        m_baddr = a & ~32'd3;
        m_bwr = !em_mem_read;
        m_be = 4'(((1 << nb) - 1) << int'(a[1:0]));
        m_bwd = (nb == 1) ? d[7:0] * 32'h0101_0101 :
                (nb == 2) ? d[15:0] * 32'h0001_0001 : d;
        m_ld_off = a[1:0]; m_ld_op = em_mem_op_type; m_ld_uns = em_mem_unsigned;
        m_rw = em_mem_read ? em_reg_write : 1'b0;
        m_dv = !em_mem_read;
        m_wd = 0;
        m_csrw = em_csr_write;
      end
    end else if (ret) begin
      m_valid = 0;
    end
  endtask

  task automatic check_model();
    chk("em_ready", em_ready, exp_ready());
    chk("mw_valid", mw_valid, m_valid);
    if (m_valid) begin
      chk("mw_rd", mw_rd, m_rd);
      chk("mw_reg_write", mw_reg_write, m_rw);
      chk("mw_mem_data_valid", mw_mem_data_valid, m_dv);
      chk("mw_csr", mw_csr, m_csr);
      chk("mw_csr_write", mw_csr_write, m_csrw);
      chk("mw_csr_data", mw_csr_data, m_csrd);
      if (m_rw || !m_dv) chk("mw_reg_write_data", mw_reg_write_data, m_wd);
    end
    chk("ma_misalign", ma_misalign, m_mis);
    if (m_mis) chk("ma_bad_addr", ma_bad_addr, m_bad);
    chk("bus_valid", bus_valid, m_phase == 1);
    if (m_phase == 1) begin
      chk("bus_addr", bus_addr, m_baddr);
      chk("bus_write", bus_write, m_bwr);
      chk("bus_byte_en", bus_byte_en, m_be);
      if (m_bwr) chk("bus_wdata", bus_wdata, m_bwd);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    em_valid = 0; em_start_handle = 0; em_reg_data_mem_addr = 0; em_csr_data_mem_data = 0;
    em_mem_read = 0; em_mem_write = 0; em_mem_op_type = 0; em_mem_unsigned = 0;
    em_rd = 0; em_reg_write = 0; em_csr = 0; em_csr_write = 0; bus_rdata_valid = 0;
  endtask

  task automatic set_op(input int kind, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd, input logic uns);
    em_valid = 1; em_start_handle = 1;
    em_mem_read = (kind == 1); em_mem_write = (kind == 2);
    em_mem_op_type = op; em_reg_data_mem_addr = a; em_csr_data_mem_data = d;
    em_rd = rd; em_reg_write = (kind != 2); em_mem_unsigned = uns;
    em_csr = 0; em_csr_write = 0;
  endtask

  task automatic drive_random();
    int kind;
    kind = $urandom_range(0, 2);
    em_valid = ($urandom_range(0, 1) == 1);
    em_start_handle = 1'($urandom_range(0, 1));
    em_mem_read = (kind == 1);
    em_mem_write = (kind == 2);
    em_mem_op_type = 2'($urandom_range(0, 3));
    em_reg_data_mem_addr = $urandom();
    if ($urandom_range(0, 1) == 1) em_reg_data_mem_addr[1:0] = 2'b00;
    em_csr_data_mem_data = $urandom();
    em_mem_unsigned = 1'($urandom_range(0, 1));
    em_rd = 5'($urandom_range(0, 31));
    em_reg_write = 1'($urandom_range(0, 1));
    em_csr = 12'($urandom_range(0, 4095));
    em_csr_write = (kind == 0) && ($urandom_range(0, 1) == 1);
    mw_ready = ($urandom_range(0, 3) != 0);
    bus_ready = 1'($urandom_range(0, 1));
    bus_rdata = $urandom();
    if (m_phase == 2) begin
      if (m_lat == 0) bus_rdata_valid = 1;
      else begin
        m_lat--;
        bus_rdata_valid = 0;
      end
    end else begin
      // Stray returns outside RESP must be ignored.
      bus_rdata_valid = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic load_test(input logic uns, input logic [31:0] exp_data);
    set_op(1, 2'd1, 32'h0000_2002, 32'h0, 5'd9, uns);
    mw_ready = 1; bus_ready = 1;
    step();
    idle_inputs();
    chk("lh_bus_addr", bus_addr, 32'h0000_2000);
    chk("lh_byte_en", bus_byte_en, 32'hC);
    chk("lh_pending", mw_mem_data_valid, 0);
    step();
    chk("lh_resp_bus_valid", bus_valid, 0);
    chk("lh_still_pending", mw_mem_data_valid, 0);
    step();
    chk("lh_wait_pending", mw_mem_data_valid, 0);
    bus_rdata = 32'h8001_0000; bus_rdata_valid = 1;
    step();
    bus_rdata_valid = 0;
    chk("lh_data", mw_reg_write_data, exp_data);
    chk("lh_data_valid", mw_mem_data_valid, 1);
    step();
  endtask

  initial begin
    rest = 0; mw_ready = 0; bus_ready = 0; bus_rdata = 0;
    idle_inputs();
    m_reset();
    #12;
    chk("rst_mw_valid", mw_valid, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_byte_en", bus_byte_en, 0);
    chk("rst_misalign", ma_misalign, 0);
    chk("rst_mw_data", mw_reg_write_data, 0);
    @(negedge clk);
    rest = 1;
    mw_ready = 1;
    step();

    // ALU pass-through
    set_op(0, 2'd0, 32'h0000_1234, 32'h0, 5'd5, 0);
    #1 chk("alu_em_ready_pre", em_ready, 1);
    step();
    idle_inputs();
    chk("alu_mw_valid", mw_valid, 1);
    chk("alu_mw_rd", mw_rd, 5);
    chk("alu_mw_data", mw_reg_write_data, 32'h1234);
    chk("alu_dv", mw_mem_data_valid, 1);
    chk("alu_em_ready", em_ready, 1);
    step();

    // SB to 0x1003, bus_ready after two waiting cycles
    set_op(2, 2'd0, 32'h0000_1003, 32'h0000_00AB, 5'd0, 0);
    bus_ready = 0;
    step();
    idle_inputs();
    chk("sb_bus_addr", bus_addr, 32'h0000_1000);
    chk("sb_byte_en", bus_byte_en, 32'h8);
    chk("sb_wdata", bus_wdata, 32'hABAB_ABAB);
    chk("sb_em_ready_1", em_ready, 0);
    step();
    chk("sb_em_ready_2", em_ready, 0);
    bus_ready = 1;
    #1 chk("sb_em_ready_3", em_ready, 0);
    step();
    chk("sb_em_ready_after", em_ready, 1);
    chk("sb_bus_valid_after", bus_valid, 0);

    // Halfword loads, signed and unsigned
    load_test(1'b0, 32'hFFFF_8001);
    load_test(1'b1, 32'h0000_8001);

    // Misaligned word load
    set_op(1, 2'd2, 32'h0000_3001, 32'h0, 5'd4, 0);
    step();
    idle_inputs();
    chk("mis_pulse", ma_misalign, 1);
    chk("mis_addr", ma_bad_addr, 32'h0000_3001);
    chk("mis_bus_valid", bus_valid, 0);
    chk("mis_reg_write", mw_reg_write, 0);
    step();
    chk("mis_pulse_end", ma_misalign, 0);
    chk("mis_bus_valid2", bus_valid, 0);

    // Backpressure from WB
    mw_ready = 0;
    set_op(0, 2'd0, 32'h0000_0011, 32'h0, 5'd7, 0);
    step();
    set_op(0, 2'd0, 32'h0000_0022, 32'h0, 5'd8, 0);
    #1 chk("bp_em_ready", em_ready, 0);
    step();
    chk("bp_hold_rd", mw_rd, 7);
    chk("bp_hold_data", mw_reg_write_data, 32'h11);
    mw_ready = 1;
    #1 chk("bp_em_ready_rel", em_ready, 1);
    step();
    idle_inputs();
    chk("bp_new_rd", mw_rd, 8);
    chk("bp_new_data", mw_reg_write_data, 32'h22);
    step();

    // Reset while a store request is outstanding
    set_op(2, 2'd2, 32'h0000_5000, 32'h1111_2222, 5'd0, 0);
    bus_ready = 0;
    step();
    idle_inputs();
    chk("rq_bus_valid", bus_valid, 1);
    rest = 0;
    #1 chk("rq_rst_bus_valid", bus_valid, 0);
    m_reset();
    @(negedge clk);
    rest = 1;
    step();

    // Reset while a load awaits data; late data must be ignored
    set_op(1, 2'd2, 32'h0000_4000, 32'h0, 5'd3, 0);
    bus_ready = 1;
    step();
    idle_inputs();
    step();
    chk("rs_in_resp", mw_mem_data_valid, 0);
    rest = 0;
    #1;
    chk("rs_bus_valid", bus_valid, 0);
    chk("rs_mw_valid", mw_valid, 0);
    m_reset();
    @(negedge clk);
    rest = 1;
    bus_rdata = 32'hDEAD_BEEF; bus_rdata_valid = 1;
    step();
    bus_rdata_valid = 0;
    chk("rs_late_data", mw_valid, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      drive_random();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
